// File: rtl/dsp_cmd_seq.sv
// Command sequencer for a pipelined DSP slice: issues operands under a credit limit,
// tags issued cycles through a LATENCY+1 pipeline and collects tagged results into a FWFT FIFO.
module dsp_cmd_seq #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opmode,
    input  logic [17:0] cmd_a,
    input  logic [17:0] cmd_b,
    input  logic [47:0] cmd_c,
    input  logic [17:0] cmd_d,
    input  logic        cmd_carryin,
    output logic [7:0]  dsp_opmode,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [47:0] dsp_c,
    output logic [17:0] dsp_d,
    output logic        dsp_carryin,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_p,
    output logic        res_carryout,
    input  logic        flush_req,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic             cnt_q, cnt_d;
    logic [LATENCY:0] tag_q, tag_d;
    logic [CW-1:0]    in_flight_q, in_flight_d;
    logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [48:0]      mem_q [DEPTH];
    logic [48:0]      head_d, res_q, push_data;
    logic [7:0]       dsp_opmode_q;
    logic [17:0]      dsp_a_q, dsp_b_q, dsp_d_q;
    logic [47:0]      dsp_c_q;
    logic             dsp_carryin_q, dsp_ce_q, dsp_rst_q, busy_q;
    logic [CW:0]      credit_used;
    logic             acc, cap, pop;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends on valid, and valid/payload are only interpreted while valid is 1.
    assign credit_used = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
    assign cmd_ready   = (state_q == S_RUN) && (credit_used < (CW+1)'(DEPTH));
    assign res_valid   = (fifo_cnt_q != '0);
    assign acc         = cmd_valid && cmd_ready;
    assign cap         = tag_q[LATENCY];
    assign pop         = res_valid && res_ready;
    assign push_data   = {dsp_carryout, dsp_p};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT, S_FLUSH: begin
                if (cnt_q) begin
                    state_d = S_RUN;
                    cnt_d   = 1'b0;
                end else begin
                    cnt_d = 1'b1;
                end
            end
            S_RUN:   if (flush_req) state_d = S_DRAIN;
            S_DRAIN: begin
                if (in_flight_q == '0) begin
                    state_d = S_FLUSH;
                    cnt_d   = 1'b0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        tag_d       = {tag_q[LATENCY-1:0], acc};
        in_flight_d = in_flight_q;
        fifo_cnt_d  = fifo_cnt_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        if (acc && !cap)      in_flight_d = in_flight_q + CW'(1);
        else if (!acc && cap) in_flight_d = in_flight_q - CW'(1);
        if (cap && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
        else if (!cap && pop) fifo_cnt_d = fifo_cnt_q - CW'(1);
        if (cap) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        if (pop) rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        // A push landing exactly at the new read slot bypasses the memory into the head register.
        head_d = (cap && (rptr_d == wptr_q)) ? push_data : mem_q[rptr_d];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_INIT;
            cnt_q         <= 1'b0;
            tag_q         <= '0;
            in_flight_q   <= '0;
            fifo_cnt_q    <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            res_q         <= '0;
            dsp_opmode_q  <= '0;
            dsp_a_q       <= '0;
            dsp_b_q       <= '0;
            dsp_c_q       <= '0;
            dsp_d_q       <= '0;
            dsp_carryin_q <= 1'b0;
            dsp_ce_q      <= 1'b0;
            dsp_rst_q     <= 1'b1;
            busy_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            in_flight_q <= in_flight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            dsp_ce_q    <= 1'b1;
            dsp_rst_q   <= (state_d == S_INIT) || (state_d == S_FLUSH);
            busy_q      <= (state_d != S_RUN) || (in_flight_d != '0);
            if (fifo_cnt_d != '0) res_q <= head_d;
            if (acc) begin
                dsp_opmode_q  <= cmd_opmode;
                dsp_a_q       <= cmd_a;
                dsp_b_q       <= cmd_b;
                dsp_c_q       <= cmd_c;
                dsp_d_q       <= cmd_d;
                dsp_carryin_q <= cmd_carryin;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (cap) mem_q[wptr_q] <= push_data;
    end

    // The credit limit on cmd_ready makes a push into a full FIFO impossible.
    assert property (@(posedge CLK) disable iff (RST)
        !(cap && !pop && (fifo_cnt_q == CW'(DEPTH))));

    assign dsp_opmode   = dsp_opmode_q;
    assign dsp_a        = dsp_a_q;
    assign dsp_b        = dsp_b_q;
    assign dsp_c        = dsp_c_q;
    assign dsp_d        = dsp_d_q;
    assign dsp_carryin  = dsp_carryin_q;
    assign dsp_ce       = dsp_ce_q;
    assign dsp_rst      = dsp_rst_q;
    assign busy         = busy_q;
    assign res_p        = res_q[47:0];
    assign res_carryout = res_q[48];
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_dsp_cmd_seq.sv
// Directed bench for dsp_cmd_seq with a 4-stage behavioural DSP slice model.
module tb_dsp_cmd_seq;
    localparam int LAT = 4;
    localparam int DEP = 4;

    logic        CLK, RST;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_opmode;
    logic [17:0] cmd_a, cmd_b, cmd_d;
    logic [47:0] cmd_c;
    logic        cmd_carryin;
    logic [7:0]  dsp_opmode;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic        dsp_carryin, dsp_ce, dsp_rst;
    logic [47:0] dsp_p;
    logic        dsp_carryout;
    logic        res_valid, res_ready;
    logic [47:0] res_p;
    logic        res_carryout;
    logic        flush_req, busy;
    logic [1:0]  dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [48:0] exp_q[$];
    logic [48:0] mdl_pipe [LAT];

    dsp_cmd_seq #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opmode(cmd_opmode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d), .cmd_carryin(cmd_carryin),
        .dsp_opmode(dsp_opmode), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_d(dsp_d),
        .dsp_carryin(dsp_carryin), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst),
        .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
        .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_carryout(res_carryout),
        .flush_req(flush_req), .busy(busy), .dbg_state(dbg_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Slice model: bit4 selects the D pre-adder (bit6 = subtract), bit7 selects P = C - M.
    function automatic logic [48:0] dsp_f(input logic [7:0] op, input logic [17:0] a,
                                          input logic [17:0] b, input logic [47:0] c,
                                          input logic [17:0] d, input logic ci);
        logic [47:0] pre, m, p;
        logic        co;
        pre = op[4] ? (op[6] ? 48'(d) - 48'(b) : 48'(d) + 48'(b)) : 48'(b);
        m   = 48'(a) * pre;
        p   = (op[7] ? c - m : m) + 48'(ci);
        co  = op[7] & (c < m);
        return {co, p};
    endfunction

    always @(posedge CLK) begin
        mdl_pipe[0] <= dsp_f(dsp_opmode, dsp_a, dsp_b, dsp_c, dsp_d, dsp_carryin);
        for (int i = 1; i < LAT; i++) mdl_pipe[i] <= mdl_pipe[i-1];
    end
    assign {dsp_carryout, dsp_p} = mdl_pipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cmd(input int op, input int a, input int b, input int c,
                           input int d, input int ci);
        cmd_opmode  = 8'(op);
        cmd_a       = 18'(a);
        cmd_b       = 18'(b);
        cmd_c       = 48'(c);
        cmd_d       = 18'(d);
        cmd_carryin = 1'(ci);
    endtask

    task automatic drain(input int n, input string tag);
        int          wait_c;
        logic [48:0] e;
        res_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_c = 0;
            while (!res_valid && wait_c < 20) begin
                tick();
                wait_c++;
            end
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 49'h0;
            check(tag, 64'({res_valid, res_carryout, res_p}), 64'({1'b1, e}));
            tick();
        end
        res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        check({tag, "_res_p"}, 64'({res_carryout, res_p}), 64'(0));
        check({tag, "_dsp_data"}, 64'({dsp_opmode, dsp_a, dsp_b, dsp_carryin}), 64'(0));
        check({tag, "_dsp_cd"}, 64'({dsp_c, dsp_d}), 64'(0));
        check({tag, "_dsp_rst"}, 64'(dsp_rst), 64'(1));
        check({tag, "_dsp_ce"}, 64'(dsp_ce), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(1));
    endtask

    initial begin
        int          acc_n, idx, wait_n, rst_n, seen;
        logic [48:0] e;
        RST = 1'b1; cmd_valid = 1'b0; flush_req = 1'b0; res_ready = 1'b0;
        set_cmd(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check_reset_outputs("reset");

        // Release: two cycles of dsp_rst, then RUN.
        RST = 1'b0;
        tick();
        check("init_dsp_rst", 64'(dsp_rst), 64'(1));
        check("init_cmd_ready", 64'(cmd_ready), 64'(0));
        check("init_dsp_ce", 64'(dsp_ce), 64'(1));
        tick();
        check("run_cmd_ready", 64'(cmd_ready), 64'(1));
        check("run_busy", 64'(busy), 64'(0));
        check("run_dsp_rst", 64'(dsp_rst), 64'(0));
        check("run_dsp_ce", 64'(dsp_ce), 64'(1));

        // Single command, latency LAT+1 to res_valid.
        set_cmd(8'hDD, 20, 10, 350, 25, 0);
        cmd_valid = 1'b1; res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("acc_opmode", 64'(dsp_opmode), 64'(8'hDD));
        check("acc_c", 64'(dsp_c), 64'(350));
        check("acc_d", 64'(dsp_d), 64'(25));
        check("acc_busy", 64'(busy), 64'(1));
        set_cmd(8'h55, 999, 1, 2, 3, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("lat_no_valid", 64'(res_valid), 64'(0));
        end
        check("hold_dsp_a", 64'(dsp_a), 64'(20));
        tick();
        check("lat_valid", 64'(res_valid), 64'(1));
        check("lat_p", 64'(res_p), 64'(48'h32));
        check("lat_carry", 64'(res_carryout), 64'(0));
        tick();
        check("lat_popped", 64'(res_valid), 64'(0));
        check("lat_idle_busy", 64'(busy), 64'(0));
        res_ready = 1'b0;

        // Back-to-back commands, results held then read in order.
        set_cmd(8'h10, 20, 10, 0, 25, 0);
        cmd_valid = 1'b1;
        check("b2b_ready0", 64'(cmd_ready), 64'(1));
        tick();
        set_cmd(8'h0A, 20, 10, 0, 0, 0);
        check("b2b_ready1", 64'(cmd_ready), 64'(1));
        tick();
        cmd_valid = 1'b0;
        repeat (8) tick();
        check("b2b_valid", 64'(res_valid), 64'(1));
        check("b2b_first", 64'(res_p), 64'(48'h2BC));
        res_ready = 1'b1;
        tick();
        check("b2b_second", 64'(res_p), 64'(48'hC8));
        tick();
        check("b2b_empty", 64'(res_valid), 64'(0));
        res_ready = 1'b0;

        // Credit limit: DEPTH acceptances with res_ready low, one more per pop.
        acc_n = 0; idx = 0; cmd_valid = 1'b1;
        repeat (20) begin
            set_cmd(8'h0A, 2*idx + 3, 6, 0, 0, 0);
            if (cmd_ready) begin
                acc_n++;
                exp_q.push_back(49'(6 * (2*idx + 3)));
                idx++;
            end
            tick();
        end
        check("credit_fill", 64'(acc_n), 64'(4));
        check("credit_stall", 64'(cmd_ready), 64'(0));
        res_ready = 1'b1;
        e = exp_q.pop_front();
        check("credit_pop", 64'({res_valid, res_carryout, res_p}), 64'({1'b1, e}));
        tick();
        res_ready = 1'b0;
        acc_n = 0;
        repeat (12) begin
            set_cmd(8'h0A, 2*idx + 3, 6, 0, 0, 0);
            if (cmd_ready) begin
                acc_n++;
                exp_q.push_back(49'(6 * (2*idx + 3)));
                idx++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("credit_one_more", 64'(acc_n), 64'(1));
        drain(4, "credit_order");
        check("credit_empty", 64'(res_valid), 64'(0));

        // Flush with 3 in flight; the third acceptance coincides with flush_req.
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_cmd(8'h0A, 2*(i+1), 100, 0, 0, 0);
            exp_q.push_back(49'(200 * (i+1)));
            if (i == 2) flush_req = 1'b1;
            check("flush_acc", 64'(cmd_ready), 64'(1));
            tick();
        end
        flush_req = 1'b0; cmd_valid = 1'b0;
        wait_n = 0; rst_n = 0;
        while (!cmd_ready && wait_n < 30) begin
            if (dsp_rst) rst_n++;
            tick();
            wait_n++;
        end
        check("flush_wait", 64'(wait_n), 64'(8));
        check("flush_dsp_rst", 64'(rst_n), 64'(2));
        check("flush_busy", 64'(busy), 64'(0));
        drain(3, "flush_order");
        check("flush_empty", 64'(res_valid), 64'(0));

        // Reset two cycles after an acceptance discards the in-flight command.
        set_cmd(8'h0A, 7, 7, 0, 0, 0);
        cmd_valid = 1'b1; res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        check_reset_outputs("midrst");
        RST = 1'b0;
        seen = 0;
        repeat (20) begin
            if (res_valid) seen++;
            tick();
        end
        check("midrst_discard", 64'(seen), 64'(0));
        check("midrst_ready", 64'(cmd_ready), 64'(1));
        res_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
